// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-scheduling blocks.
// Latency: n/a (types only). Backpressure: n/a.
package rc4_pkg;
    localparam int S_DEPTH = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WAIT_I,
        CALC_J,
        RD_J,
        WAIT_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;
endpackage

// File: rtl/ksa_shuffle_ctrl_if.sv
// Single-port 256x8 S-memory bus: address, write data and write enable out; read data back.
// Latency: set by the memory (READ_LAT). Backpressure: none, the master owns the port.
interface ksa_shuffle_ctrl_if;
    import rc4_pkg::*;

    byte_t s_address;
    byte_t s_data;
    logic  s_wren;
    byte_t s_q;

    modport master (output s_address, output s_data, output s_wren, input s_q);
    modport slave  (input s_address, input s_data, input s_wren, output s_q);
endinterface

// File: rtl/ksa_shuffle_ctrl_key_sel.sv
// Latches the secret key on accept and selects key byte (i mod KEY_BYTES).
// Latency: kb follows the index register combinationally. Backpressure: none.
module ksa_key_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   advance,
    input  logic [8*KEY_BYTES-1:0] key_in,
    output byte_t                  kb
);
    logic [8*KEY_BYTES-1:0] key_r;
    logic [8*KEY_BYTES-1:0] key_sh;
    byte_t                  idx;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            key_r <= '0;
            idx   <= '0;
        end else if (load) begin
            key_r <= key_in;
            idx   <= '0;
        end else if (advance) begin
            idx <= (idx == byte_t'(KEY_BYTES - 1)) ? '0 : idx + 8'd1;
        end
    end

    // Key byte 0 sits in the most significant byte.
    always_comb begin
        key_sh = key_r >> (8 * (KEY_BYTES - 1 - int'(idx)));
        kb     = key_sh[7:0];
    end
endmodule

// File: rtl/ksa_shuffle_ctrl.sv
// RC4 key-scheduling shuffle sequencer; sole master of the S-memory port while busy.
// Latency: 5+2*READ_LAT cycles per i, 256 iterations, then a one-cycle done pulse.
// Backpressure: none; start is only sampled in IDLE and ignored otherwise.
module ksa_shuffle_ctrl
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int READ_LAT  = 2
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    ksa_shuffle_ctrl_if.master     mem
);
    localparam byte_t LAST_I    = byte_t'(S_DEPTH - 1);
    localparam byte_t LAST_WAIT = byte_t'(READ_LAT - 1);

    ksa_state_t state;
    byte_t      i, j, si, kb, j_next;
    byte_t      wait_cnt;
    byte_t      addr_r, data_r;
    logic       wren_r;
    logic       accept;

    assign accept = (state == IDLE) && start;
    assign j_next = j + si + kb;

    ksa_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .load     (accept),
        .advance  (state == WR_J),
        .key_in   (secret_key),
        .kb       (kb)
    );

    // data_r doubles as the sj register: s[j] goes straight out as the WR_I data.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            si       <= '0;
            wait_cnt <= '0;
            addr_r   <= '0;
            data_r   <= '0;
            wren_r   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            wren_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RD_I;
                        busy   <= 1'b1;
                        i      <= '0;
                        j      <= '0;
                        addr_r <= '0;
                    end
                end
                RD_I: begin
                    wait_cnt <= '0;
                    state    <= WAIT_I;
                end
                WAIT_I: begin
                    if (wait_cnt == LAST_WAIT) begin
                        si    <= mem.s_q;
                        state <= CALC_J;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                CALC_J: begin
                    j      <= j_next;
                    addr_r <= j_next;
                    state  <= RD_J;
                end
                RD_J: begin
                    wait_cnt <= '0;
                    state    <= WAIT_J;
                end
                WAIT_J: begin
                    if (wait_cnt == LAST_WAIT) begin
                        addr_r <= i;
                        data_r <= mem.s_q;
                        wren_r <= 1'b1;
                        state  <= WR_I;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WR_I: begin
                    addr_r <= j;
                    data_r <= si;
                    wren_r <= 1'b1;
                    state  <= WR_J;
                end
                WR_J: begin
                    if (i == LAST_I) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i      <= i + 8'd1;
                        addr_r <= i + 8'd1;
                        state  <= RD_I;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.s_address = addr_r;
    assign mem.s_data    = data_r;
    assign mem.s_wren    = wren_r;
endmodule

// File: tb/tb_ksa_shuffle_ctrl.sv
module tb_ksa_shuffle_ctrl;
    logic        CLOCK_50;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic        busy;
    logic        done;

    ksa_shuffle_ctrl_if bus ();

    ksa_shuffle_ctrl #(.KEY_BYTES(3), .READ_LAT(2)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .busy       (busy),
        .done       (done),
        .mem        (bus)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Behavioural 256x8 RAM, two-cycle read latency.
    logic [7:0] mem [256];
    logic [7:0] pipe [2];
    logic       init_mem;

    always @(posedge CLOCK_50) begin
        pipe[0] <= bus.s_address;
        pipe[1] <= pipe[0];
        if (init_mem) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (bus.s_wren) begin
            mem[bus.s_address] <= bus.s_data;
        end
    end
    assign bus.s_q = mem[pipe[1]];

    // Write monitor: total writes, first writes captured, write bursts must be exactly 2 long.
    int         wcnt;
    int         run_len;
    int         bad_runs;
    logic [15:0] wlog [6];

    always @(negedge CLOCK_50) begin
        if (init_mem || !reset) begin
            wcnt     = 0;
            run_len  = 0;
            bad_runs = 0;
        end else if (bus.s_wren) begin
            if (wcnt < 6) wlog[wcnt] = {bus.s_address, bus.s_data};
            wcnt++;
            run_len++;
        end else if (run_len != 0) begin
            if (run_len != 2) bad_runs++;
            run_len = 0;
        end
    end

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] ref_s [256];

    task automatic ref_ksa(input logic [23:0] key);
        logic [7:0]  jj, t, kbyte;
        logic [23:0] sh;
        for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
        jj = 8'd0;
        for (int ii = 0; ii < 256; ii++) begin
            sh         = key >> (8 * (2 - (ii % 3)));
            kbyte      = sh[7:0];
            jj         = jj + ref_s[ii] + kbyte;
            t          = ref_s[ii];
            ref_s[ii]  = ref_s[jj];
            ref_s[jj]  = t;
        end
    endtask

    function automatic int image_diffs();
        int n = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) n++;
        return n;
    endfunction

    // One run: init memory, accept, then watch until done (or until abort_at writes).
    task automatic do_run(input logic [23:0] key, input bit poke, input int abort_at,
                          output int cyc, output int ndone);
        int guard;
        bit seen;
        cyc   = 0;
        ndone = 0;
        seen  = 0;
        guard = 0;
        init_mem = 1'b1;
        @(posedge CLOCK_50); #1;
        init_mem   = 1'b0;
        secret_key = key;
        start      = 1'b1;
        @(posedge CLOCK_50); #1;
        start      = 1'b0;
        secret_key = 24'h5A5A5A;
        check("accept_busy", {31'd0, busy}, 32'd1);
        while (!seen && guard < 3000) begin
            if (abort_at > 0 && wcnt >= abort_at) return;
            if (busy || done) cyc++;
            if (done) begin
                ndone++;
                seen = 1;
            end else begin
                start = poke && (guard < 2200) && (guard % 100 == 50);
                @(posedge CLOCK_50); #1;
                guard++;
            end
        end
        start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLOCK_50); #1;
            if (done) ndone++;
        end
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        check({pfx, "_done"}, {31'd0, done}, 32'd0);
        check({pfx, "_wren"}, {31'd0, bus.s_wren}, 32'd0);
        check({pfx, "_addr"}, {24'd0, bus.s_address}, 32'd0);
        check({pfx, "_data"}, {24'd0, bus.s_data}, 32'd0);
    endtask

    initial begin
        int cyc, nd;
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        start      = 1'b0;
        secret_key = '0;
        init_mem   = 1'b0;
        #5;
        check_outputs_zero("reset");
        #20 reset = 1'b1;

        // Key 000249: i=0 self-swap at 0, i=1 j=3, i=2 j=3+2+0x49=78.
        ref_ksa(24'h000249);
        do_run(24'h000249, 1'b0, 0, cyc, nd);
        check("k1_w0", {16'd0, wlog[0]}, {16'd0, 8'd0, 8'd0});
        check("k1_w1", {16'd0, wlog[1]}, {16'd0, 8'd0, 8'd0});
        check("k1_w2", {16'd0, wlog[2]}, {16'd0, 8'd1, 8'd3});
        check("k1_w3", {16'd0, wlog[3]}, {16'd0, 8'd3, 8'd1});
        check("k1_w4", {16'd0, wlog[4]}, {16'd0, 8'd2, 8'd78});
        check("k1_w5", {16'd0, wlog[5]}, {16'd0, 8'd78, 8'd2});
        check("k1_image", image_diffs(), 32'd0);
        check("k1_cycles", cyc, 32'd2305);
        check("k1_done_pulses", nd, 32'd1);
        check("k1_writes", wcnt, 32'd512);
        check("k1_bad_bursts", bad_runs, 32'd0);

        // Key FFFFFF: i=0 j=255, i=1 j=255+1+255 wraps to 255 (s[255] now 0).
        ref_ksa(24'hFFFFFF);
        do_run(24'hFFFFFF, 1'b0, 0, cyc, nd);
        check("kf_w0", {16'd0, wlog[0]}, {16'd0, 8'd0, 8'd255});
        check("kf_w1", {16'd0, wlog[1]}, {16'd0, 8'd255, 8'd0});
        check("kf_w2", {16'd0, wlog[2]}, {16'd0, 8'd1, 8'd0});
        check("kf_w3", {16'd0, wlog[3]}, {16'd0, 8'd255, 8'd1});
        check("kf_image", image_diffs(), 32'd0);
        check("kf_writes", wcnt, 32'd512);

        // Start pulses while busy must not restart or queue a run.
        ref_ksa(24'h000249);
        do_run(24'h000249, 1'b1, 0, cyc, nd);
        check("poke_done_pulses", nd, 32'd1);
        check("poke_cycles", cyc, 32'd2305);
        check("poke_writes", wcnt, 32'd512);
        check("poke_image", image_diffs(), 32'd0);

        // Abort at i=100 (200 writes done), then a clean rerun.
        do_run(24'h000249, 1'b0, 200, cyc, nd);
        check("abort_reached", {31'd0, busy}, 32'd1);
        #3 reset = 1'b0;
        #1;
        check_outputs_zero("abort");
        #7 reset = 1'b1;
        @(posedge CLOCK_50); #1;
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        ref_ksa(24'h000249);
        do_run(24'h000249, 1'b0, 0, cyc, nd);
        check("rerun_image", image_diffs(), 32'd0);
        check("rerun_cycles", cyc, 32'd2305);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
